counter_param: RTL and testbench



---
 rtl/counter_pkg.sv | 11 +
 rtl/counter_next_calc.sv | 47 ++++
 rtl/counter_param.sv | 55 +++++
 tb/tb_counter_param.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared mode encoding for the loadable up/down counter family.
package counter_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_UP_STEP = 2'b00;
    localparam mode_t MODE_DOWN    = 2'b01;
    localparam mode_t MODE_UP1     = 2'b10;
    localparam mode_t MODE_LOAD    = 2'b11;

endpackage

// File: rtl/counter_next_calc.sv
// Combinational next-count and carry/borrow for the three counting modes.
import counter_pkg::*;

module counter_next_calc #(
    parameter int WIDTH = 4,
    parameter int STEP  = 3
) (
    input  logic [WIDTH-1:0] Q,
    input  mode_t            mode,
    output logic [WIDTH-1:0] next_q,
    output logic             carry_borrow
);

    localparam logic [WIDTH:0] STEP_EXT = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0] ONE_EXT  = (WIDTH+1)'(1);

    logic [WIDTH:0] sum_step;
    logic [WIDTH:0] sum_one;

    // Extra MSB of each add is the carry out of the WIDTH-bit count.
    assign sum_step = {1'b0, Q} + STEP_EXT;
    assign sum_one  = {1'b0, Q} + ONE_EXT;

    always_comb begin
        next_q       = Q;
        carry_borrow = 1'b0;
        case (mode)
            MODE_UP_STEP: begin
                next_q       = sum_step[WIDTH-1:0];
                carry_borrow = sum_step[WIDTH];
            end
            MODE_DOWN: begin
                next_q       = Q - WIDTH'(1);
                carry_borrow = (Q == '0);
            end
            MODE_UP1: begin
                next_q       = sum_one[WIDTH-1:0];
                carry_borrow = sum_one[WIDTH];
            end
            default: begin
                next_q       = Q;
                carry_borrow = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/counter_param.sv
// Loadable up/down counter with registered terminal-count pulse and cascade enable.
import counter_pkg::*;

module counter_param #(
    parameter int WIDTH = 4,
    parameter int STEP  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             cin,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             rco,
    output logic             load
);

    logic [WIDTH-1:0] next_q;
    logic             carry_borrow;

    counter_next_calc #(
        .WIDTH(WIDTH),
        .STEP (STEP)
    ) u_next (
        .Q           (Q),
        .mode        (mode),
        .next_q      (next_q),
        .carry_borrow(carry_borrow)
    );

    // enable is tested before mode so an unknown mode/D while idle never reaches Q.
    always_ff @(posedge clk) begin
        if (reset) begin
            Q    <= '0;
            rco  <= 1'b0;
            load <= 1'b0;
        end else if (!enable) begin
            rco  <= 1'b0;
            load <= 1'b0;
        end else if (mode == MODE_LOAD) begin
            Q    <= D;
            rco  <= 1'b0;
            load <= 1'b1;
        end else if (cin) begin
            Q    <= next_q;
            rco  <= carry_borrow;
            load <= 1'b0;
        end else begin
            rco  <= 1'b0;
            load <= 1'b0;
        end
    end

endmodule

// File: tb/tb_counter_param.sv
// Directed bench for counter_param: single WIDTH=4/STEP=3 instance plus a two-stage STEP=1 cascade.
module tb_counter_param;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       cin;
    logic [1:0] mode;
    logic [3:0] D;
    logic [3:0] Q;
    logic       rco;
    logic       load;

    logic       c_reset;
    logic       c_enable;
    logic       c_cin_lo;
    logic [1:0] c_mode;
    logic [3:0] c_d;
    logic [3:0] lo_q;
    logic [3:0] hi_q;
    logic       lo_rco;
    logic       hi_rco;
    logic       lo_load;
    logic       hi_load;

    int n_checks = 0;
    int n_fail   = 0;
    int hi_pulses;

    always #5 clk = ~clk;

    counter_param #(.WIDTH(4), .STEP(3)) dut (
        .clk   (clk),
        .reset (reset),
        .enable(enable),
        .cin   (cin),
        .mode  (mode),
        .D     (D),
        .Q     (Q),
        .rco   (rco),
        .load  (load)
    );

    counter_param #(.WIDTH(4), .STEP(1)) u_lo (
        .clk   (clk),
        .reset (c_reset),
        .enable(c_enable),
        .cin   (c_cin_lo),
        .mode  (c_mode),
        .D     (c_d),
        .Q     (lo_q),
        .rco   (lo_rco),
        .load  (lo_load)
    );

    counter_param #(.WIDTH(4), .STEP(1)) u_hi (
        .clk   (clk),
        .reset (c_reset),
        .enable(c_enable),
        .cin   (lo_rco),
        .mode  (c_mode),
        .D     (c_d),
        .Q     (hi_q),
        .rco   (hi_rco),
        .load  (hi_load)
    );

    // Advance one edge; outputs are sampled 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] eq, input logic er, input logic el);
        check({tag, ".Q"},    {4'h0, Q},    {4'h0, eq});
        check({tag, ".rco"},  {7'h0, rco},  {7'h0, er});
        check({tag, ".load"}, {7'h0, load}, {7'h0, el});
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; cin = 1'b1; mode = 2'b11; D = 4'hA;
        c_reset = 1'b1; c_enable = 1'b1; c_cin_lo = 1'b1; c_mode = 2'b10; c_d = 4'h0;

        // Reset overrides a pending load
        step(); step();
        check_all("reset", 4'h0, 1'b0, 1'b0);
        reset = 1'b0; mode = 2'b10;
        step();
        check_all("after_reset_up1", 4'h1, 1'b0, 1'b0);

        // Up by STEP with wrap
        mode = 2'b11; D = 4'hE;
        step();
        check_all("load_e", 4'hE, 1'b0, 1'b1);
        mode = 2'b00;
        step();
        check_all("upstep_wrap", 4'h1, 1'b1, 1'b0);
        step();
        check_all("upstep_next", 4'h4, 1'b0, 1'b0);

        // Exact carry boundary: 0xD + 3 = 0x10, and 0xC + 3 = 0xF has no carry
        mode = 2'b11; D = 4'hC;
        step();
        mode = 2'b00;
        step();
        check_all("upstep_c_to_f", 4'hF, 1'b0, 1'b0);
        mode = 2'b11; D = 4'hD;
        step();
        mode = 2'b00;
        step();
        check_all("upstep_d_to_0", 4'h0, 1'b1, 1'b0);

        // Down with borrow
        mode = 2'b11; D = 4'h1;
        step();
        check_all("load_1", 4'h1, 1'b0, 1'b1);
        mode = 2'b01;
        step();
        check_all("down_1_to_0", 4'h0, 1'b0, 1'b0);
        step();
        check_all("down_borrow", 4'hF, 1'b1, 1'b0);
        step();
        check_all("down_f_to_e", 4'hE, 1'b0, 1'b0);

        // Load ignores cin; counting stalls without it
        mode = 2'b11; D = 4'h7; cin = 1'b0;
        step();
        check_all("load_cin0", 4'h7, 1'b0, 1'b1);
        mode = 2'b10;
        step();
        check_all("stall_cin0", 4'h7, 1'b0, 1'b0);

        // Enable hold, including unknown mode/D while idle
        cin = 1'b1; mode = 2'b11; D = 4'hF;
        step();
        mode = 2'b10; enable = 1'b0;
        step();
        check_all("hold_1", 4'hF, 1'b0, 1'b0);
        mode = 2'bxx; D = 4'bxxxx;
        step();
        check_all("hold_x", 4'hF, 1'b0, 1'b0);
        mode = 2'b10; D = 4'h0;
        step();
        check_all("hold_3", 4'hF, 1'b0, 1'b0);
        enable = 1'b1;
        step();
        check_all("resume_wrap", 4'h0, 1'b1, 1'b0);

        // Reset in the middle of a load stream, then resume from 0
        mode = 2'b11; D = 4'h9;
        step();
        reset = 1'b1; D = 4'h5;
        step();
        check_all("reset_mid_load", 4'h0, 1'b0, 1'b0);
        reset = 1'b0; mode = 2'b10;
        step();
        check_all("post_reset_up1", 4'h1, 1'b0, 1'b0);

        // Cascade: rco is registered, so the upper stage advances one edge after
        // the lower stage wraps; after edge c the upper count is ((c-1)/16) mod 16.
        c_reset = 1'b0;
        check("casc_start", {hi_q, lo_q}, 8'h00);
        hi_pulses = 0;
        for (int c = 1; c <= 257; c++) begin
            logic [7:0] exp_v;
            step();
            exp_v = {4'((c - 1) / 16), 4'(c)};
            check("casc_value", {hi_q, lo_q}, exp_v);
            check("casc_lo_rco", {7'h0, lo_rco}, {7'h0, (c % 16 == 0)});
            if (hi_rco) hi_pulses++;
        end
        check("casc_hi_rco_now", {7'h0, hi_rco}, 8'h01);
        check("casc_hi_pulses", 8'(hi_pulses), 8'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
